// File: rtl/mux_pipe_n.sv
// mux_pipe_n: pipelined WIDTH-bit N:1 mux tree (LSB-first 2:1 levels) with valid/ready backpressure.
// Optional build macro MUX_PIPE_N_SCAN_EN adds an auto-scan sequencer (scan_start, scan_busy, out_last).
module mux_pipe_n #(
    parameter int WIDTH     = 64,
    parameter int N         = 32,
    parameter int SEL_W     = $clog2(N),
    parameter int REG_EVERY = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*WIDTH-1:0] d,
    input  logic [SEL_W-1:0]   sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out
`ifdef MUX_PIPE_N_SCAN_EN
    ,
    input  logic               scan_start,
    output logic               scan_busy,
    output logic               out_last
`endif
);
    localparam int P = 1 << SEL_W;

    logic               adv_s;
    logic               vin_s;
    logic [SEL_W-1:0]   sin_s;
    logic [P*WIDTH-1:0] pad_s;

    // Single global enable: every stage moves together unless the output is stuck.
    assign adv_s    = !out_valid || out_ready;
    assign in_ready = adv_s;

`ifdef MUX_PIPE_N_SCAN_EN
    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SCAN = 1'b1} scan_state_e;

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N - 1);

    scan_state_e      state_r;
    scan_state_e      state_nxt_s;
    logic [SEL_W-1:0] cnt_r;
    logic             lin_s;

    // Scan state register and issue counter (advances on each accepted scan beat).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (state_r == ST_SCAN && adv_s) begin
                if (cnt_r == LAST_SEL) begin
                    cnt_r <= '0;
                end else begin
                    cnt_r <= cnt_r + SEL_W'(1);
                end
            end
        end
    end

    // Scan next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (scan_start) state_nxt_s = ST_SCAN;
                else            state_nxt_s = ST_IDLE;
            end
            ST_SCAN: begin
                if (adv_s && cnt_r == LAST_SEL) state_nxt_s = ST_IDLE;
                else                            state_nxt_s = ST_SCAN;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Scan outputs: the counter overrides the external sel/in_valid while scanning.
    always_comb begin
        scan_busy = (state_r == ST_SCAN);
        if (state_r == ST_SCAN) begin
            vin_s = 1'b1;
            sin_s = cnt_r;
            lin_s = (cnt_r == LAST_SEL);
        end else begin
            vin_s = in_valid;
            sin_s = sel;
            lin_s = 1'b0;
        end
    end
`else
    assign vin_s = in_valid;
    assign sin_s = sel;
`endif

    // Zero-pad to a full power-of-two word count so any sel >= N reads zero.
    always_comb begin
        pad_s              = '0;
        pad_s[N*WIDTH-1:0] = d;
    end

    for (genvar k = 1; k <= SEL_W; k++) begin : g_lvl
        localparam int NI        = P >> (k - 1);
        localparam int NO        = NI / 2;
        localparam bit REG_STAGE = ((k % REG_EVERY) == 0) || (k == SEL_W);

        logic [NI*WIDTH-1:0] din_s;
        logic [SEL_W-k:0]    sel_in_s;
        logic                v_in_s;
        logic [NO*WIDTH-1:0] mux_s;
        logic [NO*WIDTH-1:0] dout_s;
        logic                v_out_s;
`ifdef MUX_PIPE_N_SCAN_EN
        logic                l_in_s;
        logic                l_out_s;
`endif

        if (k == 1) begin : g_src
            assign din_s    = pad_s;
            assign sel_in_s = sin_s;
            assign v_in_s   = vin_s;
`ifdef MUX_PIPE_N_SCAN_EN
            assign l_in_s   = lin_s;
`endif
        end else begin : g_src
            assign din_s    = g_lvl[k-1].dout_s;
            assign sel_in_s = g_lvl[k-1].g_sel.sel_out_s;
            assign v_in_s   = g_lvl[k-1].v_out_s;
`ifdef MUX_PIPE_N_SCAN_EN
            assign l_in_s   = g_lvl[k-1].l_out_s;
`endif
        end

        // One 2:1 level: output word j picks from pair (2j, 2j+1) on the lowest remaining sel bit.
        always_comb begin
            mux_s = '0;
            for (int j = 0; j < NO; j++) begin
                if (sel_in_s[0]) mux_s[j*WIDTH +: WIDTH] = din_s[(2*j+1)*WIDTH +: WIDTH];
                else             mux_s[j*WIDTH +: WIDTH] = din_s[(2*j)*WIDTH +: WIDTH];
            end
        end

        if (k < SEL_W) begin : g_sel
            logic [SEL_W-k-1:0] sel_out_s;
            if (REG_STAGE) begin : g_r
                logic [SEL_W-k-1:0] sel_r;
                // Carry the not-yet-consumed sel bits along with the stage.
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n)              sel_r <= '0;
                    else if (adv_s && v_in_s)  sel_r <= sel_in_s[SEL_W-k:1];
                end
                assign sel_out_s = sel_r;
            end else begin : g_c
                assign sel_out_s = sel_in_s[SEL_W-k:1];
            end
        end

        if (REG_STAGE) begin : g_reg
            logic [NO*WIDTH-1:0] q_r;
            logic                v_r;
            // Pipeline stage: valid follows the global enable, data only loads on a valid beat.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    q_r <= '0;
                    v_r <= 1'b0;
                end else if (adv_s) begin
                    v_r <= v_in_s;
                    if (v_in_s) q_r <= mux_s;
                end
            end
            assign dout_s  = q_r;
            assign v_out_s = v_r;
`ifdef MUX_PIPE_N_SCAN_EN
            logic l_r;
            // Last-beat marker travels with its beat.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n)   l_r <= 1'b0;
                else if (adv_s) l_r <= v_in_s && l_in_s;
            end
            assign l_out_s = l_r;
`endif
        end else begin : g_comb
            assign dout_s  = mux_s;
            assign v_out_s = v_in_s;
`ifdef MUX_PIPE_N_SCAN_EN
            assign l_out_s = l_in_s;
`endif
        end
    end

    // The last level is always registered, so these are direct flop outputs.
    assign out_valid = g_lvl[SEL_W].v_out_s;
    assign out       = g_lvl[SEL_W].dout_s;
`ifdef MUX_PIPE_N_SCAN_EN
    assign out_last  = g_lvl[SEL_W].l_out_s;
`endif

endmodule

// File: tb/tb_mux_pipe_n.sv
// Directed self-checking bench for mux_pipe_n: latency, streaming, backpressure,
// non-power-of-two N, mid-flight reset and (with MUX_PIPE_N_SCAN_EN) the scan sequencer.
module tb_mux_pipe_n;
    localparam int W = 64;
    localparam logic [63:0] BASE0 = 64'hA5A5_0000_0000_0000;
    localparam logic [63:0] BASE1 = 64'hC3C3_0000_0000_0000;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic            v0, ir0, ov0, or0;
    logic [32*W-1:0] d0;
    logic [4:0]      s0;
    logic [W-1:0]    out0;

    logic            v1, ir1, ov1, or1;
    logic [20*W-1:0] d1;
    logic [4:0]      s1;
    logic [W-1:0]    out1;
`ifdef MUX_PIPE_N_SCAN_EN
    logic ss0, sb0, ol0, ss1, sb1, ol1;
`endif

    int errors = 0;
    int checks = 0;
    int stale;

    mux_pipe_n #(.WIDTH(W), .N(32), .REG_EVERY(2)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .in_valid(v0), .in_ready(ir0), .d(d0), .sel(s0),
        .out_valid(ov0), .out_ready(or0), .out(out0)
`ifdef MUX_PIPE_N_SCAN_EN
        , .scan_start(ss0), .scan_busy(sb0), .out_last(ol0)
`endif
    );

    mux_pipe_n #(.WIDTH(W), .N(20), .REG_EVERY(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .in_valid(v1), .in_ready(ir1), .d(d1), .sel(s1),
        .out_valid(ov1), .out_ready(or1), .out(out1)
`ifdef MUX_PIPE_N_SCAN_EN
        , .scan_start(ss1), .scan_busy(sb1), .out_last(ol1)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        v0 = 1'b0; s0 = 5'd0; or0 = 1'b1;
        v1 = 1'b0; s1 = 5'd0; or1 = 1'b1;
`ifdef MUX_PIPE_N_SCAN_EN
        ss0 = 1'b0; ss1 = 1'b0;
`endif
        for (int i = 0; i < 32; i++) d0[i*W +: W] = BASE0 + 64'(i);
        for (int i = 0; i < 20; i++) d1[i*W +: W] = BASE1 + 64'(i) * 64'h101;

        #1;
        check("rst_valid", 64'(ov0), 64'd0);
        check("rst_out",   out0,     64'd0);
        check("rst_ready", 64'(ir0), 64'd1);
        #10 reset_n = 1'b1;
        tick;

        // Latency: single beat sel=7 must surface exactly 3 cycles later.
        v0 = 1'b1; s0 = 5'd7;
        tick; v0 = 1'b0;
        check("lat_c1", 64'(ov0), 64'd0);
        tick;
        check("lat_c2", 64'(ov0), 64'd0);
        tick;
        check("lat_c3_v", 64'(ov0), 64'd1);
        check("lat_c3_d", out0, 64'hA5A5_0000_0000_0007);
        tick;
        check("lat_c4", 64'(ov0), 64'd0);

        // Streaming sel=0..31 back to back.
        for (int c = 0; c <= 35; c++) begin
            if (c >= 3 && c <= 34) begin
                check("stream_v", 64'(ov0), 64'd1);
                check("stream_d", out0, BASE0 + 64'(c - 3));
            end
            if (c == 35) check("stream_end", 64'(ov0), 64'd0);
            v0 = (c < 32); s0 = 5'(c);
            tick;
        end

        // Backpressure: stall 5 cycles while holding beat 3; a sel=9 offered during the stall must not enter.
        for (int c = 0; c <= 11; c++) begin
            if (c == 3) begin
                check("bp_first_v", 64'(ov0), 64'd1);
                check("bp_first_d", out0, BASE0 + 64'd3);
            end
            if (c >= 4 && c <= 8) begin
                check("bp_ready", 64'(ir0), 64'd0);
                check("bp_hold_v", 64'(ov0), 64'd1);
                check("bp_hold_d", out0, BASE0 + 64'd3);
            end
            if (c == 9)  check("bp_rel4", out0, BASE0 + 64'd4);
            if (c == 10) begin
                check("bp_rel5_v", 64'(ov0), 64'd1);
                check("bp_rel5", out0, BASE0 + 64'd5);
            end
            if (c == 11) check("bp_end", 64'(ov0), 64'd0);
            or0 = !(c >= 3 && c <= 7);
            v0  = (c <= 2) || (c >= 4 && c <= 7);
            s0  = (c <= 2) ? 5'(3 + c) : 5'd9;
            tick;
        end
        or0 = 1'b1; v0 = 1'b0;

        // N=20, one level per stage (latency 5): sel=19 then out-of-range sel=25.
        for (int c = 0; c <= 7; c++) begin
            if (c == 4) check("n20_lat", 64'(ov1), 64'd0);
            if (c == 5) begin
                check("n20_v19", 64'(ov1), 64'd1);
                check("n20_d19", out1, 64'hC3C3_0000_0000_1313);
`ifdef MUX_PIPE_N_SCAN_EN
                check("n20_last", 64'(ol1), 64'd0);
                check("n20_busy", 64'(sb1), 64'd0);
`endif
            end
            if (c == 6) begin
                check("n20_v25", 64'(ov1), 64'd1);
                check("n20_d25", out1, 64'd0);
            end
            if (c == 7) check("n20_end", 64'(ov1), 64'd0);
            v1 = (c <= 1);
            s1 = (c == 0) ? 5'd19 : 5'd25;
            tick;
        end
        v1 = 1'b0;
        check("n20_ready", 64'(ir1), 64'd1);

        // Reset with three beats in flight.
        for (int c = 0; c < 3; c++) begin
            v0 = 1'b1; s0 = 5'(10 + c);
            tick;
        end
        v0 = 1'b0;
        check("pre_rst_d", out0, BASE0 + 64'd10);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_v", 64'(ov0), 64'd0);
        check("mid_rst_d", out0, 64'd0);
        check("mid_rst_rdy", 64'(ir0), 64'd1);
        reset_n = 1'b1;
        v0 = 1'b1; s0 = 5'd31;
        tick; v0 = 1'b0;
        stale = 0;
        for (int c = 1; c <= 7; c++) begin
            if (c == 3) begin
                check("post_rst_v", 64'(ov0), 64'd1);
                check("post_rst_d", out0, BASE0 + 64'd31);
            end else if (ov0) begin
                stale++;
            end
            tick;
        end
        check("post_rst_stale", 64'(stale), 64'd0);

`ifdef MUX_PIPE_N_SCAN_EN
        // Scan: one start pulse issues d[0]..d[31], last flagged only on d[31].
        for (int c = 0; c <= 37; c++) begin
            if (c >= 1) check("scan_busy", 64'(sb0), (c <= 32) ? 64'd1 : 64'd0);
            if (c >= 4 && c <= 35) begin
                check("scan_v", 64'(ov0), 64'd1);
                check("scan_d", out0, BASE0 + 64'(c - 4));
                check("scan_last", 64'(ol0), (c == 35) ? 64'd1 : 64'd0);
            end
            if (c == 36) check("scan_end", 64'(ov0), 64'd0);
            ss0 = (c == 0); or0 = 1'b1; v0 = 1'b0;
            tick;
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
